// File: rtl/fib_seq_checker.sv
// Monitor for a 4-bit Fibonacci counter stream (0,1,1,2,3,5,8 repeating).
// Hunts for the sequence start, confirms lock, then flags deviations and counts periods.
module fib_seq_checker #(
  parameter int LOCK_LEN = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [3:0]       fib_in,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] periods,
  output logic [3:0]       exp_next
);

  typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

  localparam logic [2:0] LOCK_N = 3'(LOCK_LEN);

  state_t           state, state_d;
  logic [2:0]       idx, idx_d, idx_inc;
  logic [2:0]       cnt, cnt_d, cnt_inc;
  logic             err_d, locked_d;
  logic [CNT_W-1:0] err_cnt_d, periods_d;
  logic [3:0]       exp_d;

  function automatic logic [3:0] e_of(input logic [2:0] i);
    case (i)
      3'd0:    e_of = 4'd0;
      3'd1:    e_of = 4'd1;
      3'd2:    e_of = 4'd1;
      3'd3:    e_of = 4'd2;
      3'd4:    e_of = 4'd3;
      3'd5:    e_of = 4'd5;
      3'd6:    e_of = 4'd8;
      default: e_of = 4'd0;
    endcase
  endfunction

  assign idx_inc = (idx == 3'd6) ? 3'd0 : 3'(idx + 3'd1);
  assign cnt_inc = 3'(cnt + 3'd1);

  always_comb begin
    state_d   = state;
    idx_d     = idx;
    cnt_d     = cnt;
    err_d     = 1'b0;
    err_cnt_d = err_cnt;
    periods_d = periods;
    if (valid) begin
      case (state)
        HUNT: begin
          if (fib_in == 4'd0) begin
            state_d = CONFIRM;
            idx_d   = 3'd1;
            cnt_d   = 3'd0;
          end
        end
        CONFIRM: begin
          if (fib_in == e_of(idx)) begin
            idx_d = idx_inc;
            cnt_d = cnt_inc;
            if (cnt_inc == LOCK_N) state_d = LOCKED;
          end else if (fib_in == 4'd0) begin
            idx_d = 3'd1;
            cnt_d = 3'd0;
          end else begin
            state_d = HUNT;
            idx_d   = 3'd0;
            cnt_d   = 3'd0;
          end
        end
        LOCKED: begin
          if (fib_in == e_of(idx)) begin
            idx_d = idx_inc;
            if (idx == 3'd6) periods_d = periods + CNT_W'(1);
          end else begin
            err_d     = 1'b1;
            err_cnt_d = (err_cnt == '1) ? err_cnt : err_cnt + CNT_W'(1);
            cnt_d     = 3'd0;
            // A mismatching 0 is treated as a fresh sequence start
            if (fib_in == 4'd0) begin
              state_d = CONFIRM;
              idx_d   = 3'd1;
            end else begin
              state_d = HUNT;
              idx_d   = 3'd0;
            end
          end
        end
        default: begin
          state_d = HUNT;
          idx_d   = 3'd0;
          cnt_d   = 3'd0;
        end
      endcase
    end
    locked_d = (state_d == LOCKED);
    exp_d    = (state_d == HUNT) ? 4'd0 : e_of(idx_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= HUNT;
      idx      <= '0;
      cnt      <= '0;
      err      <= 1'b0;
      err_cnt  <= '0;
      periods  <= '0;
      locked   <= 1'b0;
      exp_next <= '0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      cnt      <= cnt_d;
      err      <= err_d;
      err_cnt  <= err_cnt_d;
      periods  <= periods_d;
      locked   <= locked_d;
      exp_next <= exp_d;
    end
  end

endmodule
